// File: rtl/wb_arbiter_s_if.sv
// Write-back arbiter bus: producer request lanes in, registered write-back beat out.
// Handshake: a producer raises I_Req[i] with I_Index/I_Data slice i and holds all three stable
// until it sees O_Ack[i] high in the same cycle; the beat transfers at that clock edge.
interface wb_arbiter_s_if #(
    parameter int NUM_REQ     = 3,
    parameter int WIDTH_DATA  = 32,
    parameter int WIDTH_INDEX = 7,
    parameter int WIDTH_SRC   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
);
    logic                           I_Stall;
    logic                           I_Buff_Full;
    logic [NUM_REQ-1:0]             I_Req;
    logic [NUM_REQ*WIDTH_INDEX-1:0] I_Index;
    logic [NUM_REQ*WIDTH_DATA-1:0]  I_Data;
    logic [NUM_REQ-1:0]             O_Ack;
    logic [NUM_REQ-1:0]             O_Busy;
    logic                           O_WB_Req;
    logic [WIDTH_INDEX-1:0]         O_WB_Index;
    logic [WIDTH_DATA-1:0]          O_WB_Data;
    logic [WIDTH_SRC-1:0]           O_WB_Src;
    logic                           O_Idle;
    // Holding-register occupancy (EMPTY/FULL per entry) and round-robin pointer
    logic [NUM_REQ-1:0]             dbg_h_valid;
    logic [WIDTH_SRC-1:0]           dbg_ptr;

    modport master (
        output I_Stall, I_Buff_Full, I_Req, I_Index, I_Data,
        input  O_Ack, O_Busy, O_WB_Req, O_WB_Index, O_WB_Data, O_WB_Src, O_Idle,
        input  dbg_h_valid, dbg_ptr
    );

    modport slave (
        input  I_Stall, I_Buff_Full, I_Req, I_Index, I_Data,
        output O_Ack, O_Busy, O_WB_Req, O_WB_Index, O_WB_Data, O_WB_Src, O_Idle,
        output dbg_h_valid, dbg_ptr
    );
endinterface

// File: rtl/wb_arbiter_s.sv
// Round-robin write-back arbiter: one holding register per producer, one registered
// write-back beat per grant, gated by pipeline stall and bypass-buffer-full.
module wb_arbiter_s #(
    parameter int NUM_REQ     = 3,
    parameter int WIDTH_DATA  = 32,
    parameter int WIDTH_INDEX = 7,
    parameter int WIDTH_SRC   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic           clock,
    input  logic           reset,
    wb_arbiter_s_if.slave  bus
);
    localparam logic [WIDTH_SRC-1:0] LAST_SRC = WIDTH_SRC'(NUM_REQ - 1);

    logic [NUM_REQ-1:0]     h_valid_q, h_valid_d;
    logic [WIDTH_INDEX-1:0] h_index_q [NUM_REQ];
    logic [WIDTH_INDEX-1:0] h_index_d [NUM_REQ];
    logic [WIDTH_DATA-1:0]  h_data_q  [NUM_REQ];
    logic [WIDTH_DATA-1:0]  h_data_d  [NUM_REQ];
    logic [WIDTH_SRC-1:0]   ptr_q, ptr_d;
    logic                   wb_req_q, wb_req_d;
    logic [WIDTH_INDEX-1:0] wb_index_q, wb_index_d;
    logic [WIDTH_DATA-1:0]  wb_data_q, wb_data_d;
    logic [WIDTH_SRC-1:0]   wb_src_q, wb_src_d;

    logic                   en;
    logic                   gnt_any;
    logic [WIDTH_SRC-1:0]   gnt_id;
    logic [NUM_REQ-1:0]     gnt;
    logic [NUM_REQ-1:0]     busy;
    logic [NUM_REQ-1:0]     ack;

    function automatic logic [WIDTH_SRC-1:0] rr_slot(input logic [WIDTH_SRC-1:0] base,
                                                     input int off);
        int sum;
        sum = int'(base) + off;
        if (sum >= NUM_REQ) sum = sum - NUM_REQ;
        return WIDTH_SRC'(sum);
    endfunction

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            h_valid_q  <= '0;
            ptr_q      <= '0;
            wb_req_q   <= 1'b0;
            wb_index_q <= '0;
            wb_data_q  <= '0;
            wb_src_q   <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                h_index_q[i] <= '0;
                h_data_q[i]  <= '0;
            end
        end else begin
            h_valid_q  <= h_valid_d;
            ptr_q      <= ptr_d;
            wb_req_q   <= wb_req_d;
            wb_index_q <= wb_index_d;
            wb_data_q  <= wb_data_d;
            wb_src_q   <= wb_src_d;
            for (int i = 0; i < NUM_REQ; i++) begin
                h_index_q[i] <= h_index_d[i];
                h_data_q[i]  <= h_data_d[i];
            end
        end
    end

    // Scan FULL entries starting at the pointer; the first hit wins.
    always_comb begin
        en      = !bus.I_Stall && !bus.I_Buff_Full;
        gnt     = '0;
        gnt_any = 1'b0;
        gnt_id  = '0;
        for (int off = 0; off < NUM_REQ; off++) begin
            if (en && !gnt_any && h_valid_q[rr_slot(ptr_q, off)]) begin
                gnt_any = 1'b1;
                gnt_id  = rr_slot(ptr_q, off);
            end
        end
        if (gnt_any) gnt[gnt_id] = 1'b1;
    end

    always_comb begin
        busy = h_valid_q & ~gnt;
        ack  = bus.I_Req & ~busy;
    end

    // A granted entry that accepts in the same cycle stays FULL with the new beat.
    always_comb begin
        h_valid_d = (h_valid_q & ~gnt) | ack;
        for (int i = 0; i < NUM_REQ; i++) begin
            h_index_d[i] = ack[i] ? bus.I_Index[i*WIDTH_INDEX +: WIDTH_INDEX] : h_index_q[i];
            h_data_d[i]  = ack[i] ? bus.I_Data[i*WIDTH_DATA +: WIDTH_DATA]    : h_data_q[i];
        end
        wb_req_d   = gnt_any;
        wb_index_d = gnt_any ? h_index_q[gnt_id] : wb_index_q;
        wb_data_d  = gnt_any ? h_data_q[gnt_id]  : wb_data_q;
        wb_src_d   = gnt_any ? gnt_id            : wb_src_q;
        ptr_d      = ptr_q;
        if (gnt_any) ptr_d = (gnt_id == LAST_SRC) ? '0 : gnt_id + WIDTH_SRC'(1);
    end

    always_comb begin
        bus.O_Ack       = ack;
        bus.O_Busy      = busy;
        bus.O_WB_Req    = wb_req_q;
        bus.O_WB_Index  = wb_index_q;
        bus.O_WB_Data   = wb_data_q;
        bus.O_WB_Src    = wb_src_q;
        bus.O_Idle      = !(|h_valid_q) && !wb_req_q;
        bus.dbg_h_valid = h_valid_q;
        bus.dbg_ptr     = ptr_q;
    end
endmodule

// File: tb/tb_wb_arbiter_s.sv
// Bench for wb_arbiter_s: slot-level reference model with per-cycle compare,
// per-requester expected queues, and directed scenarios with literal expectations.
module tb_wb_arbiter_s;
  localparam int NR = 3;
  localparam int WD = 32;
  localparam int WI = 7;
  localparam int WS = 2;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  wb_arbiter_s_if #(.NUM_REQ(NR), .WIDTH_DATA(WD), .WIDTH_INDEX(WI), .WIDTH_SRC(WS)) bus ();

  wb_arbiter_s #(.NUM_REQ(NR), .WIDTH_DATA(WD), .WIDTH_INDEX(WI), .WIDTH_SRC(WS)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  // Each producer owns one slot; beats leave in rotation order starting at m_ptr.
  bit              m_full [NR];
  logic [WI-1:0]   m_idx  [NR];
  logic [WD-1:0]   m_dat  [NR];
  int              m_ptr;
  bit              m_wb_req;
  logic [WI-1:0]   m_wb_idx;
  logic [WD-1:0]   m_wb_dat;
  int              m_wb_src;
  logic [WI+WD-1:0] exp_q [NR][$];

  function automatic int m_winner();
    if (bus.I_Stall || bus.I_Buff_Full) return -1;
    for (int off = 0; off < NR; off++)
      if (m_full[(m_ptr + off) % NR]) return (m_ptr + off) % NR;
    return -1;
  endfunction

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NR; i++) begin
        m_full[i] = 1'b0;
        m_idx[i] = '0;
        m_dat[i] = '0;
        exp_q[i].delete();
      end
      m_ptr = 0;
      m_wb_req = 1'b0;
      m_wb_idx = '0;
      m_wb_dat = '0;
      m_wb_src = 0;
    end else begin
      int w;
      bit acc [NR];
      w = m_winner();
      for (int i = 0; i < NR; i++) acc[i] = bus.I_Req[i] && !(m_full[i] && w != i);
      m_wb_req = (w >= 0);
      if (w >= 0) begin
        m_wb_idx = m_idx[w];
        m_wb_dat = m_dat[w];
        m_wb_src = w;
        m_ptr = (w + 1) % NR;
        m_full[w] = 1'b0;
      end
      for (int i = 0; i < NR; i++) begin
        if (acc[i]) begin
          m_full[i] = 1'b1;
          m_idx[i] = bus.I_Index[i*WI +: WI];
          m_dat[i] = bus.I_Data[i*WD +: WD];
          exp_q[i].push_back({bus.I_Index[i*WI +: WI], bus.I_Data[i*WD +: WD]});
        end
      end
    end
  end

  // ---------------- compare process + scoreboard ----------------
  always @(negedge clock) begin
    if (!reset) begin
      int w;
      logic [NR-1:0] e_busy;
      logic [NR-1:0] e_ack;
      bit any_full;
      logic [WI+WD-1:0] e;
      w = m_winner();
      any_full = 1'b0;
      for (int i = 0; i < NR; i++) begin
        e_busy[i] = m_full[i] && (w != i);
        any_full = any_full | m_full[i];
      end
      e_ack = bus.I_Req & ~e_busy;
      check("busy", bus.O_Busy, e_busy);
      check("ack", bus.O_Ack, e_ack);
      check("wb_req", bus.O_WB_Req, m_wb_req);
      check("wb_index", bus.O_WB_Index, m_wb_idx);
      check("wb_data", bus.O_WB_Data, m_wb_dat);
      check("wb_src", bus.O_WB_Src, m_wb_src);
      check("idle", bus.O_Idle, !any_full && !m_wb_req);
      if (bus.O_WB_Req) begin
        if (int'(bus.O_WB_Src) >= NR || exp_q[bus.O_WB_Src].size() == 0) begin
          check("sb_unexpected_beat", 1, 0);
        end else begin
          e = exp_q[bus.O_WB_Src].pop_front();
          check("sb_beat", {bus.O_WB_Index, bus.O_WB_Data}, e);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_req(input int i, input logic [WI-1:0] idx, input logic [WD-1:0] dat);
    bus.I_Req[i] = 1'b1;
    bus.I_Index[i*WI +: WI] = idx;
    bus.I_Data[i*WD +: WD] = dat;
  endtask

  task automatic clear_req();
    bus.I_Req = '0;
    bus.I_Index = '0;
    bus.I_Data = '0;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    clear_req();
    bus.I_Stall = 1'b0;
    bus.I_Buff_Full = 1'b0;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    step();
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    bus.I_Stall = 1'b0;
    bus.I_Buff_Full = 1'b0;
    clear_req();
    apply_reset();
    @(negedge clock);
    check("rst_wb_req", bus.O_WB_Req, 0);
    check("rst_idle", bus.O_Idle, 1);
    check("rst_ptr", bus.dbg_ptr, 0);
    step();

    // single request on producer 1
    drive_req(1, 7'd5, 32'hDEAD_BEEF);
    @(negedge clock);
    check("single_ack", bus.O_Ack, 3'b010);
    step();
    clear_req();
    @(negedge clock);
    check("single_no_beat_yet", bus.O_WB_Req, 0);
    step();
    @(negedge clock);
    check("single_beat_req", bus.O_WB_Req, 1);
    check("single_beat_idx", bus.O_WB_Index, 5);
    check("single_beat_data", bus.O_WB_Data, 32'hDEAD_BEEF);
    check("single_beat_src", bus.O_WB_Src, 1);
    step();
    @(negedge clock);
    check("single_one_beat", bus.O_WB_Req, 0);
    check("single_idle", bus.O_Idle, 1);
    step();

    // full contention from reset
    apply_reset();
    drive_req(0, 7'd10, 32'h1111_0000);
    drive_req(1, 7'd11, 32'h2222_0000);
    drive_req(2, 7'd12, 32'h3333_0000);
    @(negedge clock);
    check("cont_ack", bus.O_Ack, 3'b111);
    step();
    clear_req();
    @(negedge clock);
    check("cont_busy_c1", bus.O_Busy, 3'b110);
    step();
    @(negedge clock);
    check("cont_src0", bus.O_WB_Src, 0);
    check("cont_data0", bus.O_WB_Data, 32'h1111_0000);
    check("cont_busy_c2", bus.O_Busy, 3'b100);
    step();
    @(negedge clock);
    check("cont_src1", bus.O_WB_Src, 1);
    check("cont_busy_c3", bus.O_Busy, 3'b000);
    step();
    @(negedge clock);
    check("cont_src2", bus.O_WB_Src, 2);
    check("cont_data2", bus.O_WB_Data, 32'h3333_0000);
    step();
    @(negedge clock);
    check("cont_done", bus.O_WB_Req, 0);
    step();

    // round-robin wrap: grant 1 first so the pointer sits at 2
    apply_reset();
    drive_req(1, 7'd20, 32'h0000_00A1);
    step();
    clear_req();
    step();
    @(negedge clock);
    check("wrap_first_src", bus.O_WB_Src, 1);
    check("wrap_ptr2", bus.dbg_ptr, 2);
    step();
    bus.I_Stall = 1'b1;
    drive_req(0, 7'd21, 32'h0000_00B0);
    drive_req(2, 7'd22, 32'h0000_00B2);
    @(negedge clock);
    check("wrap_ack_under_stall", bus.O_Ack, 3'b101);
    step();
    clear_req();
    bus.I_Stall = 1'b0;
    @(negedge clock);
    check("wrap_busy", bus.O_Busy, 3'b001);
    step();
    @(negedge clock);
    check("wrap_src2", bus.O_WB_Src, 2);
    check("wrap_data2", bus.O_WB_Data, 32'h0000_00B2);
    check("wrap_ptr0", bus.dbg_ptr, 0);
    step();
    @(negedge clock);
    check("wrap_src0", bus.O_WB_Src, 0);
    check("wrap_data0", bus.O_WB_Data, 32'h0000_00B0);
    step();

    // back-pressure from the bypass buffer
    apply_reset();
    bus.I_Buff_Full = 1'b1;
    drive_req(0, 7'd30, 32'h0000_00C0);
    drive_req(2, 7'd32, 32'h0000_00C2);
    step();
    clear_req();
    for (int c = 0; c < 4; c++) begin
      @(negedge clock);
      check("bp_no_beat", bus.O_WB_Req, 0);
      check("bp_busy", bus.O_Busy, 3'b101);
      step();
    end
    bus.I_Buff_Full = 1'b0;
    @(negedge clock);
    check("bp_release_busy", bus.O_Busy, 3'b100);
    step();
    @(negedge clock);
    check("bp_src0", bus.O_WB_Src, 0);
    check("bp_data0", bus.O_WB_Data, 32'h0000_00C0);
    step();
    @(negedge clock);
    check("bp_src2", bus.O_WB_Src, 2);
    check("bp_data2", bus.O_WB_Data, 32'h0000_00C2);
    step();

    // streaming on producer 0: beat d-2 is visible while d is presented
    for (int d = 1; d <= 8; d++) begin
      drive_req(0, 7'd40, WD'(d));
      @(negedge clock);
      check("stream_ack", bus.O_Ack, 3'b001);
      if (d >= 3) begin
        check("stream_req", bus.O_WB_Req, 1);
        check("stream_data", bus.O_WB_Data, d - 2);
      end
      step();
    end
    clear_req();
    @(negedge clock);
    check("stream_data7", bus.O_WB_Data, 7);
    step();
    @(negedge clock);
    check("stream_data8", bus.O_WB_Data, 8);
    step();
    @(negedge clock);
    check("stream_end", bus.O_WB_Req, 0);
    step();

    // reset mid-operation with slots full and a beat on the output
    drive_req(0, 7'd50, 32'h0000_00D0);
    drive_req(1, 7'd51, 32'h0000_00D1);
    drive_req(2, 7'd52, 32'h0000_00D2);
    step();
    clear_req();
    step();
    #2 reset = 1'b1;
    #1;
    check("mid_rst_req", bus.O_WB_Req, 0);
    check("mid_rst_idx", bus.O_WB_Index, 0);
    check("mid_rst_data", bus.O_WB_Data, 0);
    check("mid_rst_src", bus.O_WB_Src, 0);
    check("mid_rst_idle", bus.O_Idle, 1);
    check("mid_rst_slots", bus.dbg_h_valid, 0);
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      @(negedge clock);
      check("post_rst_no_beat", bus.O_WB_Req, 0);
      check("post_rst_idle", bus.O_Idle, 1);
    end

    for (int i = 0; i < NR; i++) check("sb_drain", exp_q[i].size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
